nbit_sync_arb: RTL and testbench
================================

// Module: nbit_sync_arb
// PURPOSE
//  Shares one multi-bit clock-domain crossing between N_REQ requesters in the wclk domain.
//  A round-robin arbiter picks one requester and captures its data into a single crossing register.
//  A 4-phase valid/ack handshake, synchronised through SYNC_STAGES flops each way, carries the
//  data and requester ID to the rclk domain, where they are presented with a 1-cycle strobe.
//  Used wherever several wclk-side producers must post words to one rclk-side consumer.
// PARAMETERS
//  N_REQ        4   number of requesters, >= 2
//  W_DATA       32  data width per requester
//  SYNC_STAGES  2   synchroniser depth per direction, >= 1
//  W_ID         $clog2(N_REQ) (localparam)  requester ID width
// PORTS
//  wclk    in   1               write-domain clock
//  wrst_n  in   1               write-domain reset, asynchronous, active-low
//  rclk    in   1               read-domain clock
//  rrst_n  in   1               read-domain reset, asynchronous, active-low
//  req     in   N_REQ           per-requester request, level; held until matching gnt
//  wdata   in   N_REQ*W_DATA    requester i data at [i*W_DATA +: W_DATA]; sampled at the grant edge only
//  gnt     out  N_REQ           one-hot, 1-cycle pulse (wclk): data of that requester captured
//  wbusy   out  1               wclk: a transfer is in flight (state != IDLE)
//  rvalid  out  1               rclk: 1-cycle strobe, rdata/rid updated this cycle
//  rdata   out  W_DATA          rclk: last delivered data, held between strobes
//  rid     out  W_ID            rclk: requester index of rdata
// BEHAVIOUR
//  Reset: gnt=0, wbusy=0, internal wvalid=0, rr pointer=0, crossing reg=0; rvalid=0, rdata=0,
//   rid=0, rack=0. All synchroniser flops are cleared to 0.
//  W FSM (wclk), states IDLE, WAIT_ACK, WAIT_NACK:
//   IDLE: if |req, grant the first set req[i] searching from ptr upward, wrapping.
//    At that edge: cross_data<=wdata[i], cross_id<=i, wvalid<=1, ptr<=(i+1)%N_REQ, -> WAIT_ACK.
//   gnt[i] is a registered pulse, high in the first WAIT_ACK cycle. It is never high in IDLE.
//   WAIT_ACK: when ack_sync==1, wvalid<=0 and go to WAIT_NACK.
//   WAIT_NACK: when ack_sync==0, go to IDLE. A new grant is possible on the next edge.
//   While not IDLE, req is ignored. cross_data and cross_id are stable while wvalid=1 or ack_sync=1.
//  R side (rclk): valid_sync = wvalid delayed through SYNC_STAGES flops.
//   valid_sync=1 and rack=0: rdata<=cross_data, rid<=cross_id, rvalid<=1 for 1 cycle, rack<=1.
//   valid_sync=0 and rack=1: rack<=0.
//   ack_sync = rack delayed through SYNC_STAGES wclk flops.
//  Exactly one rvalid strobe is produced per gnt pulse. No duplicates and no losses.
//  Minimum spacing between grants is 2*SYNC_STAGES cycles in each domain, plus FSM overhead.
//  Fairness: a requester holding req is granted within N_REQ grants.
//  req[i] dropped before its grant is simply skipped. No grant is issued for a deasserted req.
//  Simultaneous requests: pure round-robin from ptr. ptr advances only on a grant.
//  Reset mid-transfer: both resets must be asserted together (system-level requirement).
//   If only wrst_n is asserted, wvalid falls and R clears rack with no extra strobe.
//   If only rrst_n is asserted while valid_sync=1, one duplicate strobe is permitted.
//   The bench does not check that case.
// TESTING
//  1. N_REQ=4, W_DATA=8, SYNC_STAGES=2, rclk=wclk*1.7. req=4'b0100, wdata[2]=8'hA5
//     -> gnt=4'b0100 one cycle; later one rvalid with rdata=A5, rid=2; wbusy returns to 0.
//  2. req=4'b1111 held, wdata[i]=i*8'h11 -> grants in order 0,1,2,3,0...
//     -> rvalid sequence rid 0,1,2,3 with data 00,11,22,33.
//  3. After a grant to 3, assert req=4'b1001 -> next grant is 0 (ptr wraps), then 3.
//  4. Change wdata[1] every wclk after its grant -> rdata equals the value at the grant edge.
//  5. Assert wrst_n and rrst_n together while in WAIT_ACK -> all outputs are at reset values.
//     The next request completes normally.
//  6. Sweep clock ratios 1:5 and 5:1 with random req over 1000 grants
//     -> the count of gnt pulses equals the count of rvalid strobes; the rid/data scoreboard matches.

Source files
------------

// File: rtl/nbit_sync_arb.sv
// Round-robin arbiter feeding one shared wclk->rclk crossing register.
// A 4-phase valid/ack handshake moves the captured word and requester ID to rclk.
module nbit_sync_arb #(
    parameter  int N_REQ       = 4,
    parameter  int W_DATA      = 32,
    parameter  int SYNC_STAGES = 2,
    localparam int W_ID        = $clog2(N_REQ)
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic                    rclk,
    input  logic                    rrst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*W_DATA-1:0] wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic                    wbusy,
    output logic                    rvalid,
    output logic [W_DATA-1:0]       rdata,
    output logic [W_ID-1:0]         rid
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_NACK = 2'd2
    } wstate_t;

    wstate_t           state_reg, state_next;
    logic [W_ID-1:0]   ptr_reg, ptr_next;
    logic [W_DATA-1:0] cross_data_reg, cross_data_next;
    logic [W_ID-1:0]   cross_id_reg, cross_id_next;
    logic              wvalid_reg, wvalid_next;
    logic [N_REQ-1:0]  gnt_reg, gnt_next;

    logic [SYNC_STAGES-1:0] ack_pipe_reg;
    logic [SYNC_STAGES-1:0] valid_pipe_reg;
    logic                   ack_sync;
    logic                   valid_sync;

    logic              rack_reg;
    logic              rvalid_reg;
    logic [W_DATA-1:0] rdata_reg;
    logic [W_ID-1:0]   rid_reg;

    logic [W_DATA-1:0] wdata_arr [N_REQ];
    logic              pick_found;
    logic [W_ID-1:0]   pick_idx;
    logic [W_ID-1:0]   cand;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign wdata_arr[gi] = wdata[gi*W_DATA +: W_DATA];
        end
    endgenerate

    // First set request at or above ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = W_ID'((int'(ptr_reg) + k) % N_REQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        cross_data_next = cross_data_reg;
        cross_id_next   = cross_id_reg;
        wvalid_next     = wvalid_reg;
        gnt_next        = '0;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    cross_data_next = wdata_arr[pick_idx];
                    cross_id_next   = pick_idx;
                    wvalid_next     = 1'b1;
                    ptr_next        = (pick_idx == W_ID'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    gnt_next        = N_REQ'(1) << pick_idx;
                    state_next      = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_sync) begin
                    wvalid_next = 1'b0;
                    state_next  = WAIT_NACK;
                end
            end
            WAIT_NACK: begin
                if (!ack_sync) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            cross_data_reg <= '0;
            cross_id_reg   <= '0;
            wvalid_reg     <= 1'b0;
            gnt_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            cross_data_reg <= cross_data_next;
            cross_id_reg   <= cross_id_next;
            wvalid_reg     <= wvalid_next;
            gnt_reg        <= gnt_next;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            ack_pipe_reg <= '0;
        end else begin
            ack_pipe_reg[0] <= rack_reg;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                ack_pipe_reg[s] <= ack_pipe_reg[s-1];
            end
        end
    end

    assign ack_sync = ack_pipe_reg[SYNC_STAGES-1];

    // cross_data/cross_id are held stable by the W FSM while the handshake is open.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            valid_pipe_reg <= '0;
            rack_reg       <= 1'b0;
            rvalid_reg     <= 1'b0;
            rdata_reg      <= '0;
            rid_reg        <= '0;
        end else begin
            valid_pipe_reg[0] <= wvalid_reg;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                valid_pipe_reg[s] <= valid_pipe_reg[s-1];
            end
            rvalid_reg <= 1'b0;
            if (valid_sync && !rack_reg) begin
                rdata_reg  <= cross_data_reg;
                rid_reg    <= cross_id_reg;
                rvalid_reg <= 1'b1;
                rack_reg   <= 1'b1;
            end else if (!valid_sync && rack_reg) begin
                rack_reg <= 1'b0;
            end
        end
    end

    assign valid_sync = valid_pipe_reg[SYNC_STAGES-1];

    assign gnt    = gnt_reg;
    assign wbusy  = (state_reg != IDLE);
    assign rvalid = rvalid_reg;
    assign rdata  = rdata_reg;
    assign rid    = rid_reg;

endmodule

// File: tb/tb_nbit_sync_arb.sv
// Bench for nbit_sync_arb: round-robin grant model and ID/data scoreboard
// checked every cycle, plus directed cases with literal expectations.
`timescale 1ns/1ps
module tb_nbit_sync_arb;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int S   = 2;
    localparam int WID = 2;

    typedef struct packed {
        logic [WID-1:0] id;
        logic [W-1:0]   data;
    } item_t;

    logic           wclk = 1'b0;
    logic           rclk = 1'b0;
    logic           wrst_n;
    logic           rrst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic           wbusy;
    logic           rvalid;
    logic [W-1:0]   rdata;
    logic [WID-1:0] rid;

    realtime wclk_half = 5.0;
    realtime rclk_half = 8.5;

    int    n_cmp = 0;
    int    n_err = 0;
    int    model_ptr = 0;
    int    gnt_count = 0;
    int    rv_count = 0;
    item_t sb[$];

    nbit_sync_arb #(.N_REQ(N), .W_DATA(W), .SYNC_STAGES(S)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .rclk(rclk), .rrst_n(rrst_n),
        .req(req), .wdata(wdata), .gnt(gnt), .wbusy(wbusy),
        .rvalid(rvalid), .rdata(rdata), .rid(rid)
    );

    initial forever #(wclk_half) wclk = ~wclk;
    initial forever #(rclk_half) rclk = ~rclk;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got no event, required event within bound at %0t", nm, $time);
    endtask

    // Round-robin rule: first requester at or after p, wrapping.
    function automatic int rr_pick(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // W-side model: a grant follows any edge taken in idle with a request pending.
    initial begin
        logic [N-1:0]   sreq;
        logic [N*W-1:0] sdata;
        logic [N-1:0]   exp_g;
        logic           prev_busy;
        int             busy_len;
        int             p;
        item_t          it;
        prev_busy = 1'b0;
        busy_len  = 0;
        forever begin
            @(posedge wclk);
            sreq  = req;
            sdata = wdata;
            #1;
            if (!wrst_n) begin
                prev_busy = 1'b0;
                busy_len  = 0;
                continue;
            end
            exp_g = '0;
            if (!prev_busy && sreq != '0) begin
                p = rr_pick(sreq, model_ptr);
                exp_g[p] = 1'b1;
                model_ptr = (p + 1) % N;
                it.id   = WID'(p);
                it.data = sdata[p*W +: W];
                sb.push_back(it);
                gnt_count++;
            end
            check("gnt", 32'(gnt), 32'(exp_g));
            if (exp_g != '0) check("wbusy_after_grant", 32'(wbusy), 32'd1);
            else if (!prev_busy) check("wbusy_idle", 32'(wbusy), 32'd0);
            busy_len = wbusy ? busy_len + 1 : 0;
            if (busy_len > 400) begin
                fail_timeout("wbusy_stuck");
                busy_len = 0;
            end
            prev_busy = wbusy;
        end
    end

    // R-side scoreboard: each strobe delivers the oldest outstanding grant.
    initial begin
        logic [W-1:0]   last_d;
        logic [WID-1:0] last_id;
        item_t          e;
        last_d  = '0;
        last_id = '0;
        forever begin
            @(posedge rclk);
            #1;
            if (!rrst_n) begin
                last_d  = '0;
                last_id = '0;
                continue;
            end
            if (rvalid) begin
                rv_count++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rvalid_extra: got strobe rid=%0d, required no strobe at %0t", rid, $time);
                end else begin
                    e = sb.pop_front();
                    check("rid", 32'(rid), 32'(e.id));
                    check("rdata", 32'(rdata), 32'(e.data));
                    last_d  = e.data;
                    last_id = e.id;
                end
            end else begin
                check("rdata_hold", 32'(rdata), 32'(last_d));
                check("rid_hold", 32'(rid), 32'(last_id));
            end
        end
    end

    task automatic do_reset();
        wrst_n = 1'b0;
        rrst_n = 1'b0;
        req    = '0;
        repeat (2) @(posedge wclk);
        repeat (2) @(posedge rclk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_wbusy", 32'(wbusy), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_rid", 32'(rid), 32'd0);
        sb.delete();
        model_ptr = 0;
        gnt_count = 0;
        rv_count  = 0;
        @(negedge wclk);
        wrst_n = 1'b1;
        rrst_n = 1'b1;
    endtask

    task automatic wait_gnt(output logic [N-1:0] g);
        g = '0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge wclk);
            #1;
            if (gnt != '0) begin
                g = gnt;
                return;
            end
        end
        fail_timeout("gnt_wait");
    endtask

    task automatic wait_rvalid(output logic [WID-1:0] id, output logic [W-1:0] d);
        id = '0;
        d  = '0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge rclk);
            #1;
            if (rvalid) begin
                id = rid;
                d  = rdata;
                return;
            end
        end
        fail_timeout("rvalid_wait");
    endtask

    task automatic drain();
        @(negedge wclk);
        req = '0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge wclk);
            #1;
            if (!wbusy && sb.size() == 0) begin
                check("strobes_eq_grants", 32'(rv_count), 32'(gnt_count));
                return;
            end
        end
        fail_timeout("drain");
    endtask

    task automatic random_phase(int ngrants);
        int start;
        int guard;
        start = gnt_count;
        guard = 0;
        while (gnt_count - start < ngrants && guard < 40000) begin
            @(negedge wclk);
            guard++;
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(3) == 0) req[i] = 1'b1;
                else if (req[i] && $urandom_range(63) == 0) req[i] = 1'b0;
            end
            wdata = $urandom;
        end
        if (guard >= 40000) fail_timeout("random_grants");
        drain();
        check("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [N-1:0]   g;
        logic [WID-1:0] id;
        logic [W-1:0]   d;
        logic [W-1:0]   exp4;
        logic [W-1:0]   v;
        logic           seen;
        req   = '0;
        wdata = '0;
        do_reset();

        // Single request from requester 2.
        wdata[2*W +: W] = 8'hA5;
        @(negedge wclk) req = 4'b0100;
        wait_gnt(g);
        check("t1_gnt", 32'(g), 32'h4);
        @(negedge wclk) req = '0;
        wait_rvalid(id, d);
        check("t1_rid", 32'(id), 32'd2);
        check("t1_rdata", 32'(d), 32'hA5);
        drain();
        check("t1_wbusy", 32'(wbusy), 32'd0);

        // All requesting from ptr=0: strict rotation.
        do_reset();
        for (int i = 0; i < N; i++) wdata[i*W +: W] = W'(i * 8'h11);
        @(negedge wclk) req = 4'b1111;
        for (int k = 0; k < N; k++) begin
            wait_rvalid(id, d);
            check("t2_rid", 32'(id), 32'(k));
            check("t2_rdata", 32'(d), 32'(k * 8'h11));
        end
        drain();

        // Pointer wrap after granting requester 3.
        @(negedge wclk) req = 4'b1000;
        wait_gnt(g);
        check("t3_gnt3", 32'(g), 32'h8);
        @(negedge wclk) req = 4'b1001;
        wait_gnt(g);
        check("t3_gnt0", 32'(g), 32'h1);
        @(negedge wclk) req = 4'b1000;
        wait_gnt(g);
        check("t3_gnt3b", 32'(g), 32'h8);
        drain();

        // Data changes every cycle; delivered word is the one present at the grant edge.
        exp4 = '0;
        seen = 1'b0;
        v    = '0;
        fork
            begin
                for (int c = 0; c < 120; c++) begin
                    @(negedge wclk);
                    if (gnt[1] && !seen) begin
                        exp4 = v;
                        seen = 1'b1;
                        req  = '0;
                    end
                    if (c == 0) req = 4'b0010;
                    v = W'($urandom);
                    wdata[1*W +: W] = v;
                end
            end
            begin
                wait_rvalid(id, d);
            end
        join
        check("t4_seen", 32'(seen), 32'd1);
        check("t4_rid", 32'(id), 32'd1);
        check("t4_rdata", 32'(d), 32'(exp4));
        drain();

        // Reset both domains while waiting for ack, then a normal transfer.
        @(negedge wclk) req = 4'b0100;
        wait_gnt(g);
        check("t5_gnt", 32'(g), 32'h4);
        #2;
        do_reset();
        wdata[0 +: W] = 8'h3C;
        @(negedge wclk) req = 4'b0001;
        wait_gnt(g);
        check("t5_gnt_after", 32'(g), 32'h1);
        @(negedge wclk) req = '0;
        wait_rvalid(id, d);
        check("t5_rid", 32'(id), 32'd0);
        check("t5_rdata", 32'(d), 32'h3C);
        drain();

        // Random traffic at extreme clock ratios.
        wclk_half = 5.0;
        rclk_half = 25.0;
        random_phase(500);
        wclk_half = 25.0;
        rclk_half = 5.0;
        random_phase(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: got no completion, required finish within 10ms");
        $fatal(1, "watchdog expired");
    end

endmodule
